// File: rtl/add_sub_seq.sv
// Slice-serial two's-complement adder/subtractor with valid/ready handshakes and registered flags.
// Optional ADD_SUB_SAT_EN macro enables signed saturation of the final result.
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Ctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N   = WIDTH / SLICE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_v;
  logic             r_z;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE:0]   w_sum;
  logic [WIDTH-1:0] w_part;
  logic [WIDTH-1:0] w_res;
  logic             w_last;
  logic             w_v;

  // Select the active slice and merge its sum into the partial result.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sa   = '0;
    w_sb   = '0;
    w_part = r_acc;
    for (int i = 0; i < N; i++) begin
      if (i == int'(r_cnt)) begin
        w_sa = r_a[i*SLICE +: SLICE];
        w_sb = r_b[i*SLICE +: SLICE];
      end
    end
    w_sum = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, r_carry};
    for (int i = 0; i < N; i++) begin
      if (i == int'(r_cnt)) begin
        w_part[i*SLICE +: SLICE] = w_sum[SLICE-1:0];
      end
    end
  end

  // Carry into the MSB equals a ^ b ^ sum at that bit, so V needs no extra adder.
  assign w_last = (r_cnt == CW'(N - 1));
  assign w_v    = r_a[MSB] ^ r_b[MSB] ^ w_part[MSB] ^ w_sum[SLICE];

`ifdef ADD_SUB_SAT_EN
  always_comb begin
    w_res = w_part;
    if (w_v) begin
      w_res = r_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res = w_part;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_v         <= 1'b0;
      r_z         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B ^ {WIDTH{Ctr}};
            r_carry    <= Cin | Ctr;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_acc   <= w_part;
          r_carry <= w_sum[SLICE];
          if (w_last) begin
            r_s         <= w_res;
            r_cout      <= w_sum[SLICE];
            r_v         <= w_v;
            r_z         <= (w_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign V         = r_v;
  assign Z         = r_z;

endmodule

// File: tb/tb_add_sub_seq.sv
// Directed self-checking bench for add_sub_seq (WIDTH=16, SLICE=4).
// Expected values are hand-computed; saturated variants follow ADD_SUB_SAT_EN.
module tb_add_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Ctr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] S;
  logic        Cout;
  logic        V;
  logic        Z;

  int total = 0;
  int bad   = 0;

  add_sub_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Ctr      (Ctr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout),
    .V        (V),
    .Z        (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept one operation, wait for out_valid (bounded), check latency and results.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ctr, input logic [15:0] exp_s,
                        input logic exp_c, input logic exp_v, input logic exp_z);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    A = a; B = b; Cin = cin; Ctr = ctr; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; Cin = ~cin; Ctr = ~ctr;
    n = 0;
    while (n <= 20) begin
      n++;
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_S"}, 32'(S), 32'(exp_s));
    check({tag, "_Cout"}, 32'(Cout), 32'(exp_c));
    check({tag, "_V"}, 32'(V), 32'(exp_v));
    check({tag, "_Z"}, 32'(Z), 32'(exp_z));
  endtask

  // Complete the output handshake and confirm the held result survives it.
  task automatic release_out(input string tag);
    logic [15:0] held;
    held = S;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_ir_set"}, 32'(in_ready), 32'd1);
    check({tag, "_S_kept"}, 32'(S), 32'(held));
  endtask

  initial begin
    logic [15:0] sat_s;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Ctr = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_flags", 32'({Cout, V, Z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0, 1'b0);
    release_out("add");
    run_op("add_cin", 16'h1234, 16'h0FF1, 1'b1, 1'b0, 16'h2226, 1'b0, 1'b0, 1'b0);
    release_out("add_cin");
    run_op("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    release_out("sub");
    run_op("sub_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    release_out("sub_cin");
    run_op("sub_eq", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_out("sub_eq");

`ifdef ADD_SUB_SAT_EN
    sat_s = 16'h7FFF;
`else
    sat_s = 16'h8000;
`endif
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_s, 1'b0, 1'b1, 1'b0);
    release_out("ovf_add");
`ifdef ADD_SUB_SAT_EN
    sat_s = 16'h8000;
`else
    sat_s = 16'h7FFF;
`endif
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, sat_s, 1'b1, 1'b1, 1'b0);
    release_out("ovf_sub");

    // Backpressure: result held while inputs churn and in_valid toggles.
    run_op("bp", 16'h00A0, 16'h0B0C, 1'b0, 1'b0, 16'h0BAC, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      A = 16'(i * 16'h1111);
      B = 16'(16'hFFFF - i);
      @(posedge clk);
      #1;
      check("bp_S", 32'(S), 32'h0BAC);
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_ir", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    run_op("post_bp", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    release_out("post_bp");

    // Reset during the 2nd CALC cycle aborts the operation.
    @(negedge clk);
    A = 16'h4444; B = 16'h1111; Cin = 1'b0; Ctr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ir", 32'(in_ready), 32'd1);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_S", 32'(S), 32'd0);
    check("mid_rst_flags", 32'({Cout, V, Z}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_ov", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    release_out("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, slice-serial adder/subtractor for the ULA datapath. It computes `A + B + Cin` or `A − B` (two's complement) on `WIDTH`-bit operands, `SLICE` bits per clock. It uses a valid/ready handshake on both sides and registered result flags (carry, signed overflow, zero). It replaces the fixed 8-bit combinational ripple add/sub where wide operands or a shorter critical path are needed.

## Interface
- `WIDTH`, default 16: operand/result width. Must be ≥ 2 and a multiple of `SLICE`.
- `SLICE`, default 4: bits processed per cycle. `N = WIDTH/SLICE` compute cycles.
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: one clock; reset is asynchronous and active-low.
- `in_valid`, input, 1: operands and control are valid.
- `in_ready`, output, 1: block can accept an operation.
- `A`, input, WIDTH: operand A.
- `B`, input, WIDTH: operand B.
- `Cin`, input, 1: carry in, used for addition only.
- `Ctr`, input, 1: 1 = subtract (A − B), 0 = add.
- `out_valid`, output, 1: result and flags are valid.
- `out_ready`, input, 1: consumer accepts the result.
- `S`, output, WIDTH: result.
- `Cout`, output, 1: carry out of MSB. For subtraction, 1 = no borrow.
- `V`, output, 1: signed overflow.
- `Z`, output, 1: `S == 0`.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`: capture `A` and `B_eff = B ^ {WIDTH{Ctr}}`.
  - Set carry register to `Cin | Ctr`. When `Ctr=1`, `Cin` has no effect.
  - Clear slice counter `cnt` to 0, then go to CALC.
- CALC:
  - Each cycle, add slice `cnt` (bits `cnt*SLICE +: SLICE`) of A and B_eff plus the carry register.
  - Write the slice sum into the result register and update the carry register.
  - When `cnt == N−1`:
    - Compute `Cout` = final carry.
    - Compute `V` = carry into MSB XOR carry out of MSB.
    - Compute `Z` = (final S == 0).
    - Go to DONE.
  - Otherwise increment `cnt`.
- DONE:
  - `out_valid = 1`.
  - `S`, `Cout`, `V`, `Z` are held stable while `out_ready = 0`.
  - On `out_ready`, go to IDLE.
- `in_ready = 1` only in IDLE. There is no overlap or pipelining; `in_valid` outside IDLE is ignored.
- Input pins are sampled only at the accept edge. Changes on `A`, `B`, `Cin`, `Ctr` during CALC/DONE have no effect.
- `S`, `Cout`, `V`, `Z` keep their last values after leaving DONE, until the next DONE overwrites them.
- Arithmetic is modulo 2^WIDTH. `S` and `Cout` match `{Cout,S} = A + B_eff + (Cin|Ctr)` exactly.

## Timing
- Reset values (asynchronous, while `rst_n = 0`):
  - State IDLE, `cnt = 0`.
  - `in_ready = 1`, `out_valid = 0`.
  - `S = 0`, `Cout = 0`, `V = 0`, `Z = 0`.
- Latency: operation accepted at edge k → `out_valid` rises after edge k+N.
  - `SLICE = WIDTH` gives N = 1, i.e. one CALC cycle.
- Throughput: one operation per N+2 cycles when `out_ready` is held at 1.
- `out_valid` and `out_ready` both high at edge t → `out_valid = 0` and `in_ready = 1` after t. A new accept is possible at edge t+1 at the earliest.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. All outputs go to their reset values; no partial result is ever flagged valid.
- All outputs are driven from registers or decoded state only. There is no combinational path from inputs to outputs.

## Configuration
- `ADD_SUB_SAT_EN` defined: signed saturation.
  - When the final `V = 1`, `S` is forced to `A[MSB] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}`.
  - `V` still reports 1. `Cout` is unaffected. `Z` is computed on the saturated `S`.
- `ADD_SUB_SAT_EN` undefined: `S` is the modulo result. No saturation logic is synthesised.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
1. Add `0x1234 + 0x0FF1`, `Cin=0`, `Ctr=0` → `S=0x2225`, `Cout=0`, `V=0`, `Z=0`. `out_valid` rises exactly 4 cycles after accept. `Cin=1` → `S=0x2226`.
2. Subtract `0x0005 − 0x0007`, `Ctr=1`, `Cin=0` → `S=0xFFFE`, `Cout=0`, `V=0`. Repeating with `Cin=1` gives an identical result.
3. Equal subtract `0x1234 − 0x1234` → `S=0x0000`, `Z=1`, `Cout=1`, `V=0`.
4. Overflow cases:
   - `0x7FFF + 0x0001` → `V=1`, `Cout=0`. `S=0x8000` without the macro; `S=0x7FFF` with `ADD_SUB_SAT_EN`.
   - `0x8000 − 0x0001` → `V=1`, `Cout=1`. `S=0x7FFF` without the macro; `S=0x8000` with it.
5. Backpressure: hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid`, `A`, `B` → outputs stable, `in_ready=0`, no new op accepted. Release → `in_ready=1` the next cycle.
6. Reset: assert `rst_n=0` in the 2nd CALC cycle → all outputs at reset values, `in_ready=1`. The next operation `0x00FF + 0x0001` → `S=0x0100` after 4 cycles.
